// File: rtl/csm_pkg.sv
// Shared types and constants for the CSM port responder and its lock table.
package csm_pkg;
  localparam int NUM_REGS       = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int ADDR_W         = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_ADDR   = 2'b01,
    ERR_LOCKED = 2'b10,
    ERR_PROTO  = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    WDATA  = 2'b10,
    RESP   = 2'b11
  } state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/csm_lock_table.sv
// Per-port lock ownership: raises the hold request in RESP, resolves same-register
// contention against the peer (PORT_ID 0 wins) and commits hold/release on RESP exit.
module csm_lock_table
  import csm_pkg::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                resp_ok_i,
  input  logic [ADDR_W-1:0]   idx_i,
  input  logic                hold_i,
  input  logic                rel_i,
  input  logic [NUM_REGS-1:0] peer_hold_req_i,
  output logic [NUM_REGS-1:0] lock_own_o,
  output logic [NUM_REGS-1:0] hold_req_o,
  output logic                lose_o
);
  logic [NUM_REGS-1:0] own_q, own_d;
  logic [NUM_REGS-1:0] sel;

  assign sel        = reg_onehot(idx_i);
  assign hold_req_o = (resp_ok_i && hold_i) ? sel : '0;
  assign lose_o     = (PORT_ID != 0) && (|(hold_req_o & peer_hold_req_i));
  assign lock_own_o = own_q;

  always_comb begin
    own_d = own_q;
    if (resp_ok_i && !lose_o) begin
      if (hold_i) own_d = own_q | sel;
      if (rel_i)  own_d = own_q & ~sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) own_q <= '0;
    else          own_q <= own_d;
  end
endmodule

// File: rtl/csm_port_responder.sv
// One processor port onto a lockable 8-entry register file over a multiplexed AD bus.
// Define CSM_WDATA_TIMEOUT_EN to abort a write whose data phase stalls too long.
module csm_port_responder
  import csm_pkg::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          in_AD,
  input  logic                rw,
  input  logic                enable,
  input  logic                hold,
  input  logic                release_i,
  output logic                ack,
  output logic [1:0]          err,
  output logic [7:0]          out_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  output logic [NUM_REGS-1:0] lock_own,
  input  logic [NUM_REGS-1:0] lock_peer,
  output logic [NUM_REGS-1:0] hold_req,
  input  logic [NUM_REGS-1:0] peer_hold_req
);
  state_t            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic              rw_q, rw_d, hold_q, hold_d, rel_q, rel_d;
  err_t              err_q, err_d, dec_err, resp_err;
  logic [ADDR_W-1:0] idx;
  logic              resp_ok, lose, timeout;

  assign idx = addr_q[ADDR_W-1:0];

`ifdef CSM_WDATA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] stall_q, stall_d;

  assign stall_d = (state_q == WDATA && !enable) ? stall_q + 1'b1 : '0;
  assign timeout = (state_q == WDATA) && !enable && (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Error checks in priority order; only the first failing rule is reported.
  always_comb begin
    dec_err = ERR_OK;
    if (addr_q[7:ADDR_W] != '0)     dec_err = ERR_ADDR;
    else if (lock_peer[idx])        dec_err = ERR_LOCKED;
    else if (hold_q && rel_q)       dec_err = ERR_PROTO;
    else if (rel_q && !lock_own[idx]) dec_err = ERR_PROTO;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    err_d   = err_q;
    ack     = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          addr_d  = in_AD;
          rw_d    = rw;
          hold_d  = hold;
          rel_d   = release_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        err_d = dec_err;
        if (dec_err == ERR_OK && rw_q) begin
          ack     = 1'b1;
          state_d = WDATA;
        end else begin
          state_d = RESP;
        end
      end
      WDATA: begin
        if (enable) begin
          mem_we  = 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = ERR_PROTO;
          state_d = RESP;
        end
      end
      RESP: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      hold_q  <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
    end
  end

  assign resp_ok = (state_q == RESP) && (err_q == ERR_OK);

  csm_lock_table #(.PORT_ID(PORT_ID)) u_locks (
    .clk             (clk),
    .reset_n         (reset_n),
    .resp_ok_i       (resp_ok),
    .idx_i           (idx),
    .hold_i          (hold_q),
    .rel_i           (rel_q),
    .peer_hold_req_i (peer_hold_req),
    .lock_own_o      (lock_own),
    .hold_req_o      (hold_req),
    .lose_o          (lose)
  );

  // Losing a same-cycle lock race turns an otherwise good response into a peer-lock error.
  assign resp_err  = lose ? ERR_LOCKED : err_q;
  assign err       = (state_q == RESP) ? resp_err : ERR_OK;
  assign out_data  = (state_q == RESP && !rw_q && resp_err == ERR_OK) ? mem_rdata : '0;
  assign mem_addr  = idx;
  assign mem_wdata = mem_we ? in_AD : '0;
endmodule

// File: tb/tb_csm_port_responder.sv
// Two responders (PORT_ID 0 and 1) share stimulus; each sees its own register file.
module tb_csm_port_responder;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] in_AD;
  logic rw, enable, hold, rel;
  logic [7:0] lock_peer, peer_hold_req;

  logic [1:0]      ack, mem_we;
  logic [1:0][1:0] err;
  logic [1:0][7:0] out_data, mem_wdata, mem_rdata, lock_own, hold_req;
  logic [1:0][2:0] mem_addr;

  logic [7:0] tb_mem [2][8] = '{'{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
                                '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}};
  int we_cnt [2] = '{0, 0};

  logic [7:0] mem_m [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] own_m [2];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csm_port_responder #(.PORT_ID(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_AD(in_AD), .rw(rw), .enable(enable), .hold(hold),
    .release_i(rel), .ack(ack[0]), .err(err[0]), .out_data(out_data[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .lock_own(lock_own[0]), .lock_peer(lock_peer),
    .hold_req(hold_req[0]), .peer_hold_req(peer_hold_req)
  );

  csm_port_responder #(.PORT_ID(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_AD(in_AD), .rw(rw), .enable(enable), .hold(hold),
    .release_i(rel), .ack(ack[1]), .err(err[1]), .out_data(out_data[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .lock_own(lock_own[1]), .lock_peer(lock_peer),
    .hold_req(hold_req[1]), .peer_hold_req(peer_hold_req)
  );

  assign mem_rdata[0] = tb_mem[0][mem_addr[0]];
  assign mem_rdata[1] = tb_mem[1][mem_addr[1]];

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mem_we[p]) begin
        tb_mem[p][mem_addr[p]] <= mem_wdata[p];
        we_cnt[p] <= we_cnt[p] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Error rules as stated for the port: first failing rule wins, then lock race.
  function automatic logic [1:0] model_err(input int a, input bit h, input bit r,
                                           input logic [7:0] plk, input logic [7:0] own,
                                           input logic [7:0] preq, input int pid);
    int i = a % 8;
    if (a >= 8)                     return 2'd1;
    if (plk[i])                     return 2'd2;
    if (h && r)                     return 2'd3;
    if (r && !own[i])               return 2'd3;
    if (h && pid == 1 && preq[i])   return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_reset(input string tag);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s.p%0d.ack", tag, p), ack[p], 0);
      check($sformatf("%s.p%0d.err", tag, p), err[p], 0);
      check($sformatf("%s.p%0d.out_data", tag, p), out_data[p], 0);
      check($sformatf("%s.p%0d.mem_we", tag, p), mem_we[p], 0);
      check($sformatf("%s.p%0d.mem_addr", tag, p), mem_addr[p], 0);
      check($sformatf("%s.p%0d.mem_wdata", tag, p), mem_wdata[p], 0);
      check($sformatf("%s.p%0d.lock_own", tag, p), lock_own[p], 0);
      check($sformatf("%s.p%0d.hold_req", tag, p), hold_req[p], 0);
    end
  endtask

  task automatic txn(input string tag, input logic [7:0] a, input bit w, input bit h,
                     input bit r, input logic [7:0] wd, input logic [7:0] plk,
                     input logic [7:0] preq, input int gap);
    logic [1:0] dec [2];
    logic [1:0] fin [2];
    int wc0 [2];
    int i;
    bit wpath;
    i = int'(a) % 8;
    for (int p = 0; p < 2; p++) begin
      dec[p] = model_err(int'(a), h, r, plk, own_m[p], 8'h00, p);
      fin[p] = model_err(int'(a), h, r, plk, own_m[p], preq, p);
      wc0[p] = we_cnt[p];
    end
    wpath = w && (dec[0] == 2'd0);

    @(negedge clk);
    in_AD = a; rw = w; hold = h; rel = r; enable = 1'b1;
    lock_peer = plk; peer_hold_req = preq;

    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s.p%0d.dec_ack", tag, p), ack[p], (w && dec[p] == 2'd0));
      check($sformatf("%s.p%0d.dec_we", tag, p), mem_we[p], 0);
    end
    in_AD  = 8'($urandom);
    enable = wpath ? 1'b0 : 1'($urandom);

    if (wpath) begin
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
          check($sformatf("%s.p%0d.wait_we", tag, p), mem_we[p], 0);
          check($sformatf("%s.p%0d.wait_ack", tag, p), ack[p], 0);
        end
      end
      @(negedge clk);
      in_AD = wd; enable = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s.p%0d.we", tag, p), mem_we[p], 1);
        check($sformatf("%s.p%0d.waddr", tag, p), mem_addr[p], i);
        check($sformatf("%s.p%0d.wdata", tag, p), mem_wdata[p], wd);
      end
    end

    @(negedge clk);
    enable = 1'b0;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s.p%0d.resp_ack", tag, p), ack[p], 1);
      check($sformatf("%s.p%0d.resp_err", tag, p), err[p], fin[p]);
      check($sformatf("%s.p%0d.resp_we", tag, p), mem_we[p], 0);
      check($sformatf("%s.p%0d.hold_req", tag, p), hold_req[p],
            (h && dec[p] == 2'd0) ? (32'd1 << i) : 32'd0);
      if (!w && fin[p] == 2'd0)
        check($sformatf("%s.p%0d.rdata", tag, p), out_data[p], mem_m[i]);
    end

    @(negedge clk);
    lock_peer = 8'h00; peer_hold_req = 8'h00;
    for (int p = 0; p < 2; p++) begin
      if (fin[p] == 2'd0) begin
        if (h) own_m[p] = own_m[p] | (8'd1 << i);
        if (r) own_m[p] = own_m[p] & ~(8'd1 << i);
      end
    end
    if (w && dec[0] == 2'd0) mem_m[i] = wd;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s.p%0d.idle_ack", tag, p), ack[p], 0);
      check($sformatf("%s.p%0d.lock_own", tag, p), lock_own[p], own_m[p]);
      check($sformatf("%s.p%0d.writes", tag, p), we_cnt[p] - wc0[p], (w && dec[p] == 2'd0));
      check($sformatf("%s.p%0d.memval", tag, p), tb_mem[p][i], mem_m[i]);
    end
  endtask

  initial begin
    int wc0 [2];
    reset_n = 1'b0; in_AD = 8'h00; rw = 1'b0; enable = 1'b0; hold = 1'b0; rel = 1'b0;
    lock_peer = 8'h00; peer_hold_req = 8'h00;
    own_m = '{8'h00, 8'h00};
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;

    txn("wr03",   8'h03, 1, 0, 0, 8'hA5, 8'h00, 8'h00, 0);
    txn("rd03",   8'h03, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    check("rd03.value", mem_m[3], 8'hA5);
    txn("bad08",  8'h08, 1, 0, 0, 8'h77, 8'h00, 8'h00, 0);
    txn("peer2",  8'h02, 1, 0, 0, 8'h99, 8'h04, 8'h00, 0);
    txn("hold5",  8'h05, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    check("hold5.own", lock_own[0], 8'h20);
    txn("hold5b", 8'h05, 1, 1, 0, 8'h5C, 8'h00, 8'h00, 1);
    txn("rel5",   8'h05, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);
    check("rel5.own", lock_own[0], 8'h00);
    txn("rel5b",  8'h05, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);
    txn("holdrel", 8'h04, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0);
    txn("wrgap",  8'h07, 1, 0, 0, 8'h3C, 8'h00, 8'h00, 3);

    for (int n = 0; n < 40; n++) begin
      txn($sformatf("rnd%0d", n), 8'($urandom_range(0, 11)), 1'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom & $urandom & $urandom), 8'h00,
          int'($urandom_range(0, 3)));
    end

    if (own_m[0][1]) txn("unlock1", 8'h01, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);
    txn("race1", 8'h01, 0, 1, 0, 8'h00, 8'h00, 8'h02, 0);
    check("race1.p0_own_bit", lock_own[0][1], 1);
    check("race1.p1_own_bit", lock_own[1][1], 0);

    @(negedge clk);
    in_AD = 8'h06; rw = 1'b1; hold = 1'b0; rel = 1'b0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    wc0[0] = we_cnt[0]; wc0[1] = we_cnt[1];
    in_AD = 8'h5A; enable = 1'b1; reset_n = 1'b0;
    #1;
    check_reset("rst_wdata");
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rst_wdata.p%0d.writes", p), we_cnt[p] - wc0[p], 0);
      check($sformatf("rst_wdata.p%0d.mem6", p), tb_mem[p][6], mem_m[6]);
    end
    enable = 1'b0; reset_n = 1'b1;
    own_m = '{8'h00, 8'h00};
    #1;
    check_reset("post_rst");
    txn("rd06", 8'h06, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csm_port_responder.md
CSM_PORT_RESPONDER -- requirements
Module: csm_port_responder

Interface
REQ-001 The block SHALL have parameter PORT_ID, default 0, meaning this port's identity; PORT_ID 0 wins simultaneous lock contention.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  the single clock.
- reset_n  input  1  asynchronous active-low reset.
- in_AD  input  8  multiplexed bus: address in the address phase, write data in the data phase.
- rw  input  1  1 = write, 0 = read; sampled in the address phase.
- enable  input  1  phase strobe from the processor.
- hold  input  1  lock the addressed register after a successful access.
- release  input  1  unlock the addressed register after a successful access.
- ack  output  1  one-cycle completion, or data-ready pulse.
- err  output  2  status: 00 ok, 01 bad address, 10 locked by peer, 11 protocol error.
- out_data  output  8  read data, valid while ack=1 in RESP.
- mem_addr  output  3  register-file index.
- mem_we  output  1  register-file write strobe, one cycle.
- mem_wdata  output  8  register-file write data.
- mem_rdata  input  8  register-file read data, combinational from mem_addr.
- lock_own  output  8  registers held by this port.
- lock_peer  input  8  registers held by the other port.
- hold_req  output  8  one-hot lock request, valid in RESP.
- peer_hold_req  input  8  the other port's one-hot lock request.

Function
REQ-003 The FSM SHALL have the states IDLE, DECODE, WDATA and RESP.
REQ-004 In IDLE with enable=1, the block SHALL capture in_AD, rw, hold and release, then go to DECODE.
REQ-005 In DECODE, the block SHALL check errors in priority order and go to RESP:
- in_AD[7:3]!=0 gives err 01.
- lock_peer[addr]=1 gives err 10.
- hold=1 with release=1 gives err 11.
- release=1 with lock_own[addr]=0 gives err 11.
REQ-006 In DECODE with no error: a write SHALL go to WDATA and pulse ack for one cycle; a read SHALL go to RESP.
REQ-007 In WDATA with enable=1, the block SHALL drive mem_we=1, mem_wdata=in_AD and mem_addr=addr for exactly one cycle, then go to RESP.
REQ-008 In RESP, the block SHALL drive ack=1 for one cycle with the err code; for a read with err 00, out_data SHALL equal mem_rdata; it SHALL then return to IDLE.
REQ-009 On an err 00 access with hold=1, the block SHALL set lock_own[addr] at the RESP-to-IDLE edge; on release=1 it SHALL clear that bit.
REQ-010 When peer_hold_req matches hold_req on the same register in the same RESP cycle, PORT_ID 0 SHALL take the lock; PORT_ID 1 SHALL report err 10 and leave lock_own unchanged.
REQ-011 An access to a register this port already holds SHALL succeed; hold on an owned register SHALL be a no-op returning err 00.
REQ-012 An errored transaction SHALL cause no mem_we pulse and no change to lock_own.
REQ-013 Latency SHALL be 2 cycles from IDLE enable to the RESP ack for a read, and RESP SHALL follow one cycle after the WDATA enable for a write.
REQ-014 The enable input SHALL be ignored in DECODE and RESP.

Reset
REQ-015 While reset_n=0, the block SHALL drive ack=0, err=00, out_data=00, mem_we=0, mem_addr=0, mem_wdata=00, lock_own=00 and hold_req=00, with the FSM in IDLE.
REQ-016 A reset in the middle of WDATA SHALL abort the transaction with no write, and all locks held by this port SHALL be released.

Configuration
REQ-017 With CSM_WDATA_TIMEOUT_EN defined, 16 consecutive WDATA cycles with enable=0 SHALL abort the transaction to RESP with err 11 and no write.
REQ-018 Without CSM_WDATA_TIMEOUT_EN, WDATA SHALL wait indefinitely.

Structure
REQ-019 The shared package csm_pkg SHALL hold:
- the err_t enum: ERR_OK, ERR_ADDR, ERR_LOCKED, ERR_PROTO;
- the state_t enum;
- NUM_REGS=8;
- TIMEOUT_CYCLES=16.
REQ-020 The lock bookkeeping (lock_own update, contention resolution) SHALL be a sub-module named csm_lock_table.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Write in_AD=03, rw=1, then data A5 -> ack in DECODE, then mem_we=1 with mem_addr=3 and mem_wdata=A5, then ack with err 00.
- Read address 03 with mem_rdata=A5 -> ack with err 00 and out_data=A5, 2 cycles after enable.
- in_AD=08 -> ack with err 01, no mem_we.
- lock_peer=0x04 and a write to address 2 -> err 10, no mem_we.
- hold on address 5 -> lock_own=0x20; release on address 5 -> lock_own=0x00; release again -> err 11.
- Simultaneous hold of address 1 with PORT_ID=1 -> err 10, lock_own unchanged; reset_n=0 during WDATA -> no write, all outputs at reset values.
